sd_init_seq: RTL

SD-card identification/initialisation sequencer that drives the command transmitter's request interface (enable pulse, 6-bit command index, 32-bit argument).
- Issues the fixed SD 2.0 power-up sequence CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7.
- Checks responses delivered by the response receiver and reports the card RCA.
- Sits between the FAT32 top-level control and the sdio_tx / response-receiver pair, all on the system clock.

---
 rtl/sd_init_seq.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/sd_init_seq.sv
// sd_init_seq: SD 2.0 identification sequencer driving the command transmitter.
// CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7 with response checks.
module sd_init_seq #(
  parameter int GAP_CYCLES  = 8,
  parameter int RSP_TIMEOUT = 1024,
  parameter int ACMD41_MAX  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  output logic        o_cmd_en,
  output logic [5:0]  o_cmd,
  output logic [31:0] o_para,
  input  logic        i_tx_done,
  input  logic        i_rsp_valid,
  input  logic [31:0] i_rsp_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic [5:0]  o_err_cmd,
  output logic [15:0] o_rca
);

  localparam int RW = $clog2(ACMD41_MAX) + 1;
  localparam int TW = $clog2(RSP_TIMEOUT) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;

  localparam logic [RW-1:0] RLAST = RW'(ACMD41_MAX - 1);
  localparam logic [TW-1:0] TLAST = TW'(RSP_TIMEOUT - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_TX,
    WAIT_RSP,
    GAP,
    DONE,
    ERR
  } state_e;

  typedef enum logic [2:0] {
    ST_CMD0,
    ST_CMD8,
    ST_CMD55,
    ST_ACMD41,
    ST_CMD2,
    ST_CMD3,
    ST_CMD7
  } step_e;

  state_e        r_state;
  step_e         r_step;
  logic          r_fin;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_tcnt;
  logic [GW-1:0] r_gcnt;

  logic          r_cmd_en;
  logic [5:0]    r_cmd;
  logic [31:0]   r_para;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_err_code;
  logic [5:0]    r_err_cmd;
  logic [15:0]   r_rca;

  logic [5:0]    w_cmd;
  logic [31:0]   w_para;
  logic          w_unused;

  assign w_unused = ^i_rsp_data[15:12];

  always_comb begin
    w_cmd  = 6'd0;
    w_para = 32'h0000_0000;
    unique case (r_step)
      ST_CMD0: w_cmd = 6'd0;
      ST_CMD8: begin
        w_cmd  = 6'd8;
        w_para = 32'h0000_01AA;
      end
      ST_CMD55: w_cmd = 6'd55;
      ST_ACMD41: begin
        w_cmd  = 6'd41;
        w_para = 32'h40FF_8000;
      end
      ST_CMD2: w_cmd = 6'd2;
      ST_CMD3: w_cmd = 6'd3;
      ST_CMD7: begin
        w_cmd  = 6'd7;
        w_para = {r_rca, 16'h0000};
      end
      default: w_cmd = 6'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_step     <= ST_CMD0;
      r_fin      <= 1'b0;
      r_retry    <= '0;
      r_tcnt     <= '0;
      r_gcnt     <= '0;
      r_cmd_en   <= 1'b0;
      r_cmd      <= 6'd0;
      r_para     <= 32'h0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_err_cmd  <= 6'd0;
      r_rca      <= 16'h0;
    end else begin
      r_cmd_en <= 1'b0;
      unique case (r_state)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            r_state    <= ISSUE;
            r_step     <= ST_CMD0;
            r_fin      <= 1'b0;
            r_retry    <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_err_cmd  <= 6'd0;
            r_rca      <= 16'h0;
          end
        end
        ISSUE: begin
          r_cmd_en <= 1'b1;
          r_cmd    <= w_cmd;
          r_para   <= w_para;
          r_state  <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            r_tcnt <= '0;
            r_gcnt <= '0;
            if (r_step == ST_CMD0) begin
              r_step  <= ST_CMD8;
              r_state <= GAP;
            end else begin
              r_state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (i_rsp_valid) begin
            r_state <= GAP;
            r_gcnt  <= '0;
            unique case (r_step)
              ST_CMD8: begin
                if (i_rsp_data[11:0] == 12'h1AA) begin
                  r_step <= ST_CMD55;
                end else begin
                  r_state    <= ERR;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= 2'd1;
                  r_err_cmd  <= r_cmd;
                end
              end
              ST_CMD55: r_step <= ST_ACMD41;
              ST_ACMD41: begin
                if (i_rsp_data[31]) begin
                  r_step <= ST_CMD2;
                end else if (r_retry == RLAST) begin
                  r_state    <= ERR;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= 2'd2;
                  r_err_cmd  <= r_cmd;
                end else begin
                  r_retry <= r_retry + 1'b1;
                  r_step  <= ST_CMD55;
                end
              end
              ST_CMD2: r_step <= ST_CMD3;
              ST_CMD3: begin
                r_rca  <= i_rsp_data[31:16];
                r_step <= ST_CMD7;
              end
              ST_CMD7: r_fin <= 1'b1;
              default: r_step <= ST_CMD8;
            endcase
          end else if (r_tcnt == TLAST) begin
            // No response by the last counted cycle: timeout
            r_state    <= ERR;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= 2'd3;
            r_err_cmd  <= r_cmd;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        GAP: begin
          if (r_gcnt == GLAST) begin
            if (r_fin) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ISSUE;
            end
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_en   = r_cmd_en;
  assign o_cmd      = r_cmd;
  assign o_para     = r_para;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;
  assign o_err_cmd  = r_err_cmd;
  assign o_rca      = r_rca;

endmodule
